// File: rtl/call_sequencer.sv
// call_sequencer: call/return/interrupt control for the return-address stack.
// Drives push/pop to the stack and redirects the PC; tracks stack depth.
module call_sequencer #(
    parameter logic [9:0] VECTOR    = 10'h3F0,
    parameter bit         IE_RESET  = 1'b1,
    parameter int         DEPTH_MAX = 8
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       call,
    input  logic       ret,
    input  logic       reti,
    input  logic       irq,
    input  logic [9:0] pc_ret,
    input  logic [9:0] dest,
    input  logic [9:0] outpop,
    output logic       push,
    output logic       pop,
    output logic [9:0] inpush,
    output logic       pc_load,
    output logic [9:0] pc_out,
    output logic       stall,
    output logic       ie,
    output logic [3:0] depth,
    output logic       ovf,
    output logic       unf
);

    typedef enum logic {
        S_IDLE,
        S_RET_WAIT
    } state_t;

    localparam logic [3:0] L_MAX = 4'(DEPTH_MAX);

    state_t     r_state;
    logic [3:0] r_depth;
    logic       r_ovf;
    logic       r_unf;
    logic       r_ie;
    logic       r_is_reti;

    state_t     w_next;
    logic [3:0] w_depth_nxt;
    logic       w_ovf_set;
    logic       w_unf_set;
    logic       w_ie_nxt;
    logic       w_is_reti_nxt;
    logic       w_push;
    logic       w_pop;
    logic       w_load;
    logic       w_stall;
    logic [9:0] w_pc_out;
    logic       w_full;

    assign w_full = (r_depth >= L_MAX);

    // Next-state and Mealy outputs; ret/reti beat call, call beats irq.
    always_comb begin
        w_next        = r_state;
        w_depth_nxt   = r_depth;
        w_ovf_set     = 1'b0;
        w_unf_set     = 1'b0;
        w_ie_nxt      = r_ie;
        w_is_reti_nxt = r_is_reti;
        w_push        = 1'b0;
        w_pop         = 1'b0;
        w_load        = 1'b0;
        w_stall       = 1'b0;
        w_pc_out      = dest;
        unique case (r_state)
            S_IDLE: begin
                if (ret || reti) begin
                    if (r_depth != 4'd0) begin
                        w_pop         = 1'b1;
                        w_stall       = 1'b1;
                        w_depth_nxt   = r_depth - 4'd1;
                        w_is_reti_nxt = reti;
                        w_next        = S_RET_WAIT;
                    end else begin
                        w_unf_set = 1'b1;
                        if (reti) w_ie_nxt = 1'b1;
                    end
                end else if (call || (irq && r_ie)) begin
                    w_load   = 1'b1;
                    w_pc_out = call ? dest : VECTOR;
                    if (!call) w_ie_nxt = 1'b0;
                    if (w_full) begin
                        w_ovf_set = 1'b1;
                    end else begin
                        w_push      = 1'b1;
                        w_depth_nxt = r_depth + 4'd1;
                    end
                end
            end
            S_RET_WAIT: begin
                w_load   = 1'b1;
                w_stall  = 1'b1;
                w_pc_out = outpop;
                if (r_is_reti) w_ie_nxt = 1'b1;
                w_next   = S_IDLE;
            end
        endcase
    end

    // State, depth, flags; a reset cycle wins over any pending return.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state   <= S_IDLE;
            r_depth   <= 4'd0;
            r_ovf     <= 1'b0;
            r_unf     <= 1'b0;
            r_ie      <= IE_RESET;
            r_is_reti <= 1'b0;
        end else begin
            r_state   <= w_next;
            r_depth   <= w_depth_nxt;
            r_ovf     <= r_ovf | w_ovf_set;
            r_unf     <= r_unf | w_unf_set;
            r_ie      <= w_ie_nxt;
            r_is_reti <= w_is_reti_nxt;
        end
    end

    // Strobes are suppressed in a reset cycle so no jump lands on that edge.
    always_comb begin
        push    = w_push & ~reset;
        pop     = w_pop & ~reset;
        pc_load = w_load & ~reset;
        stall   = w_stall & ~reset;
    end

    assign pc_out = w_pc_out;
    assign inpush = pc_ret;
    assign ie     = r_ie;
    assign depth  = r_depth;
    assign ovf    = r_ovf;
    assign unf    = r_unf;

endmodule

// File: tb/tb_call_sequencer.sv
// Bench for call_sequencer: directed vector table, overflow loop and
// randomized traffic against a stack-based reference model.
module tb_call_sequencer;

    logic       clk = 1'b0;
    logic       reset, call, ret, reti, irq;
    logic [9:0] pc_ret, dest, outpop;
    logic       push, pop, pc_load, stall, ie, ovf, unf;
    logic [9:0] inpush, pc_out;
    logic [3:0] depth;

    always #5 clk = ~clk;

    call_sequencer dut (
        .clk(clk), .reset(reset), .call(call), .ret(ret), .reti(reti),
        .irq(irq), .pc_ret(pc_ret), .dest(dest), .outpop(outpop),
        .push(push), .pop(pop), .inpush(inpush), .pc_load(pc_load),
        .pc_out(pc_out), .stall(stall), .ie(ie), .depth(depth),
        .ovf(ovf), .unf(unf)
    );

    int n_tests = 0;
    int n_fail  = 0;

    // Reference model: the stack contents themselves plus a pending return.
    logic [9:0] q[$];
    bit         m_wait, m_isreti, m_ie, m_ovf, m_unf;
    logic [9:0] m_popped;

    typedef struct {
        bit         rst, c, r, ri, iq;
        logic [9:0] pr, ds;
        bit         push, pop, load;
        logic [9:0] out;
        bit         stall;
        logic [3:0] dep;
        bit         ie, unf;
    } vec_t;

    vec_t tbl[$];

    task automatic chk(input string nm, input logic [9:0] act,
                       input logic [9:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t",
                     nm, act, exp, $time);
        end
    endtask

    task automatic drive(input bit rs, input bit c, input bit r,
                         input bit ri, input bit iq,
                         input logic [9:0] pr, input logic [9:0] ds);
        reset  = rs;
        call   = c;
        ret    = r;
        reti   = ri;
        irq    = iq;
        pc_ret = pr;
        dest   = ds;
        outpop = m_wait ? m_popped : 10'($urandom);
    endtask

    // Evaluate one cycle of the model, compare, then advance the model.
    task automatic model_step(input bit en);
        bit         e_push, e_pop, e_load, e_stall;
        logic [9:0] e_out;
        int         sd;
        bit         sie, sovf, sunf;
        sd   = q.size();
        sie  = m_ie;
        sovf = m_ovf;
        sunf = m_unf;
        e_push = 0; e_pop = 0; e_load = 0; e_stall = 0;
        e_out  = 10'd0;
        if (reset) begin
            q.delete();
            m_wait = 0; m_isreti = 0; m_ie = 1;
            m_ovf = 0; m_unf = 0;
        end else if (m_wait) begin
            e_load = 1; e_stall = 1; e_out = m_popped;
            if (m_isreti) m_ie = 1;
            m_wait = 0;
        end else if (ret || reti) begin
            if (q.size() > 0) begin
                e_pop = 1; e_stall = 1;
                m_popped = q.pop_back();
                m_isreti = reti;
                m_wait = 1;
            end else begin
                m_unf = 1;
                if (reti) m_ie = 1;
            end
        end else if (call || (irq && m_ie)) begin
            e_load = 1;
            e_out  = call ? dest : 10'h3F0;
            if (!call) m_ie = 0;
            if (q.size() < 8) begin
                e_push = 1;
                q.push_back(pc_ret);
            end else begin
                m_ovf = 1;
            end
        end
        if (en) begin
            chk("m_push", 10'(push), 10'(e_push));
            chk("m_pop", 10'(pop), 10'(e_pop));
            chk("m_load", 10'(pc_load), 10'(e_load));
            chk("m_stall", 10'(stall), 10'(e_stall));
            if (e_load) chk("m_pc_out", pc_out, e_out);
            if (e_push) chk("m_inpush", inpush, pc_ret);
            chk("m_depth", 10'(depth), 10'(sd));
            chk("m_ie", 10'(ie), 10'(sie));
            chk("m_ovf", 10'(ovf), 10'(sovf));
            chk("m_unf", 10'(unf), 10'(sunf));
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic vec_t mk(bit rs, bit c, bit r, bit ri, bit iq,
                                logic [9:0] pr, logic [9:0] ds,
                                bit ep, bit eo, bit el, logic [9:0] eout,
                                bit es, logic [3:0] ed, bit ei, bit eu);
        vec_t v;
        v.rst = rs; v.c = c; v.r = r; v.ri = ri; v.iq = iq;
        v.pr = pr; v.ds = ds;
        v.push = ep; v.pop = eo; v.load = el; v.out = eout;
        v.stall = es; v.dep = ed; v.ie = ei; v.unf = eu;
        return v;
    endfunction

    initial begin
        // reset / nested calls
        tbl.push_back(mk(1,0,0,0,0, 10'h000,10'h000, 0,0,0,10'h000,0, 0,1,0));
        tbl.push_back(mk(0,1,0,0,0, 10'h005,10'h010, 1,0,1,10'h010,0, 0,1,0));
        tbl.push_back(mk(0,1,0,0,0, 10'h012,10'h020, 1,0,1,10'h020,0, 1,1,0));
        tbl.push_back(mk(0,0,1,0,0, 10'h013,10'h000, 0,1,0,10'h000,1, 2,1,0));
        tbl.push_back(mk(0,0,0,0,0, 10'h000,10'h000, 0,0,1,10'h012,1, 1,1,0));
        tbl.push_back(mk(0,0,1,0,0, 10'h013,10'h000, 0,1,0,10'h000,1, 1,1,0));
        tbl.push_back(mk(0,0,0,0,0, 10'h000,10'h000, 0,0,1,10'h005,1, 0,1,0));
        tbl.push_back(mk(0,0,0,0,0, 10'h000,10'h000, 0,0,0,10'h000,0, 0,1,0));
        // underflow
        tbl.push_back(mk(0,0,1,0,0, 10'h000,10'h000, 0,0,0,10'h000,0, 0,1,0));
        tbl.push_back(mk(0,0,0,0,0, 10'h000,10'h000, 0,0,0,10'h000,0, 0,1,1));
        // interrupt round trip, irq held while disabled
        tbl.push_back(mk(0,0,0,0,1, 10'h044,10'h000, 1,0,1,10'h3F0,0, 0,1,1));
        tbl.push_back(mk(0,0,0,0,1, 10'h045,10'h000, 0,0,0,10'h000,0, 1,0,1));
        tbl.push_back(mk(0,0,0,1,1, 10'h046,10'h000, 0,1,0,10'h000,1, 1,0,1));
        tbl.push_back(mk(0,0,0,0,1, 10'h000,10'h000, 0,0,1,10'h044,1, 0,0,1));
        tbl.push_back(mk(0,0,0,0,0, 10'h000,10'h000, 0,0,0,10'h000,0, 0,1,1));
        // call beats irq, irq taken next cycle
        tbl.push_back(mk(0,1,0,0,1, 10'h007,10'h0AB, 1,0,1,10'h0AB,0, 0,1,1));
        tbl.push_back(mk(0,0,0,0,1, 10'h00C,10'h000, 1,0,1,10'h3F0,0, 1,1,1));
        tbl.push_back(mk(0,0,0,0,0, 10'h000,10'h000, 0,0,0,10'h000,0, 2,0,1));
        // reset during the return wait cycle
        tbl.push_back(mk(0,0,1,0,0, 10'h000,10'h000, 0,1,0,10'h000,1, 2,0,1));
        tbl.push_back(mk(1,0,0,0,0, 10'h000,10'h000, 0,0,0,10'h000,0, 1,0,1));
        tbl.push_back(mk(0,0,0,0,0, 10'h000,10'h000, 0,0,0,10'h000,0, 0,1,0));

        m_wait = 0;
        drive(1, 0, 0, 0, 0, 10'h0, 10'h0);
        #3;
        model_step(0);
        tick();

        foreach (tbl[i]) begin
            drive(tbl[i].rst, tbl[i].c, tbl[i].r, tbl[i].ri, tbl[i].iq,
                  tbl[i].pr, tbl[i].ds);
            #3;
            model_step(1);
            chk($sformatf("v%0d_push", i), 10'(push), 10'(tbl[i].push));
            chk($sformatf("v%0d_pop", i), 10'(pop), 10'(tbl[i].pop));
            chk($sformatf("v%0d_load", i), 10'(pc_load), 10'(tbl[i].load));
            chk($sformatf("v%0d_stall", i), 10'(stall), 10'(tbl[i].stall));
            if (tbl[i].load)
                chk($sformatf("v%0d_pc_out", i), pc_out, tbl[i].out);
            if (tbl[i].push)
                chk($sformatf("v%0d_inpush", i), inpush, tbl[i].pr);
            chk($sformatf("v%0d_depth", i), 10'(depth), 10'(tbl[i].dep));
            chk($sformatf("v%0d_ie", i), 10'(ie), 10'(tbl[i].ie));
            chk($sformatf("v%0d_unf", i), 10'(unf), 10'(tbl[i].unf));
            tick();
        end

        // Nine calls from empty: eight pushes then a flagged overflow.
        for (int i = 0; i < 9; i++) begin
            drive(0, 1, 0, 0, 0, 10'(i + 'h100), 10'(i + 'h200));
            #3;
            model_step(1);
            chk("ovf_push", 10'(push), 10'(i < 8));
            chk("ovf_load", 10'(pc_load), 10'd1);
            chk("ovf_pc_out", pc_out, 10'(i + 'h200));
            tick();
        end
        drive(0, 0, 0, 0, 0, 10'h0, 10'h0);
        #3;
        model_step(1);
        chk("ovf_flag", 10'(ovf), 10'd1);
        chk("ovf_depth", 10'(depth), 10'd8);
        tick();

        // Random traffic against the model.
        for (int n = 0; n < 3000; n++) begin
            drive(($urandom_range(0, 63) == 0) || (n == 0),
                  $urandom_range(0, 99) < 45,
                  $urandom_range(0, 99) < 22,
                  $urandom_range(0, 99) < 10,
                  $urandom_range(0, 99) < 35,
                  10'($urandom), 10'($urandom));
            #3;
            model_step(1);
            tick();
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/call_sequencer.md
# call_sequencer

Control block that drives the 8-entry, 10-bit return-address stack (`pila`) for subroutine calls, returns and a single-level-vectored interrupt. It sits between the instruction decoder and the PC path: it issues `push`/`pop` to the stack, supplies the stack write data, and tells the PC register when and where to jump. It also tracks stack depth so that overflow and underflow are caught and flagged instead of silently wrapping the stack pointer.

## Interface
Parameters:
- `VECTOR`, 10'h3F0: interrupt entry address.
- `IE_RESET`, 1: value of `ie` after reset.
- `DEPTH_MAX`, 8: stack capacity; must match `pila`.

Ports:
- `clk` in 1: system clock, rising edge.
- `reset` in 1: synchronous, active-high. Also fans out to `pila`.
- `call` in 1: decoder, current instruction is a call.
- `ret` in 1: decoder, current instruction is a return.
- `reti` in 1: decoder, current instruction is a return from interrupt.
- `irq` in 1: level interrupt request; held by the source until serviced.
- `pc_ret` in 10: resume address, the PC of the next sequential instruction.
- `dest` in 10: call target address.
- `outpop` in 10: stack read data; valid the cycle after `pop`.
- `push` out 1: to `pila`.
- `pop` out 1: to `pila`.
- `inpush` out 10: to `pila`, always equal to `pc_ret`.
- `pc_load` out 1: PC mux select; PC takes `pc_out` at the next edge.
- `pc_out` out 10: jump address.
- `stall` out 1: freezes fetch and decode for this cycle.
- `ie` out 1: interrupt enable.
- `depth` out 4: current stack occupancy, 0..8.
- `ovf` out 1: sticky overflow flag.
- `unf` out 1: sticky underflow flag.

## Operation
- FSM has two states: IDLE and RET_WAIT. Reset state is IDLE.
- IDLE: outputs are combinational (Mealy). Event priority is `ret`/`reti` > `call` > `irq`. `irq` is only taken when `ie`=1 and no instruction event is present.
  - **call**:
    - `push`=1 if `depth`<8; otherwise `push`=0 and `ovf`<=1.
    - `pc_load`=1, `pc_out`=`dest`.
    - `depth`+1 if pushed.
  - **irq**:
    - Same push and overflow rules as call.
    - `pc_out`=`VECTOR`, `ie`<=0.
    - A pending `irq` lost to a call is taken on the next eligible cycle.
  - **ret/reti with `depth`>0**:
    - `pop`=1, `stall`=1, `depth`-1.
    - Latch a flag `is_reti`<=`reti`.
    - Go to RET_WAIT.
  - **ret/reti with `depth`=0**:
    - No pop, no jump, no stall; `unf`<=1; stay in IDLE.
    - `reti` still sets `ie`<=1.
- RET_WAIT:
  - `pc_load`=1, `pc_out`=`outpop`, `stall`=1.
  - If `is_reti`, then `ie`<=1.
  - All inputs except `reset` are ignored; no push or pop is issued.
  - Return to IDLE.
- `ret` and `reti` both asserted: treated as `reti`.
- `depth` is 4-bit and saturates at 0..8; it never wraps.
- `ovf` and `unf` clear only on reset.

## Timing
- Reset (synchronous): state=IDLE, `depth`=0, `ovf`=0, `unf`=0, `ie`=`IE_RESET`, `is_reti`=0. Consequently `push`=`pop`=`pc_load`=`stall`=0.
- Reset asserted while in RET_WAIT: return to IDLE; `pc_load` is not issued at or after that edge.
- Call and irq latency: the jump takes 1 cycle; PC equals the target at edge N+1.
- Return latency: `pop` in cycle N, `pc_load` in cycle N+1, PC equals the return address at edge N+2. `stall` is high in N and N+1.
- `inpush` is valid in the same cycle as `push`. `pila` writes at the edge ending that cycle.
- `irq` asserted during RET_WAIT is evaluated in the following IDLE cycle.
- Back-to-back calls: one per cycle, no bubble.

## Test plan
- **Nested calls**:
  - Stimulus: reset, then call `dest`=0x010/`pc_ret`=0x005, call 0x020/0x012, ret, ret.
  - Required: `push` on cycles 1–2; `depth` goes 1, 2, 1, 0. Returns load 0x012 then 0x005, each 2 cycles with `stall` high; `unf`=0.
- **Overflow**:
  - Stimulus: 9 consecutive calls.
  - Required: 8 pushes; the 9th has `push`=0, `pc_load`=1, `ovf`=1, `depth`=8.
- **Underflow**:
  - Stimulus: `ret` at `depth`=0.
  - Required: `pop`=0, `pc_load`=0, `stall`=0, `unf`=1, `depth`=0.
- **Interrupt round trip**:
  - Stimulus: `irq`=1, `ie`=1, `pc_ret`=0x044; then `reti`.
  - Required: `push` with `inpush`=0x044, `pc_out`=0x3F0, `ie`=0 next cycle. After `reti`, `pc_out`=0x044 in the RET_WAIT cycle and `ie`=1 after that edge. `irq` held with `ie`=0 causes no second entry.
- **Priority**:
  - Stimulus: `call` and `irq` together.
  - Required: the call is taken, `pc_out`=`dest`; `irq` is taken the next cycle with `pc_out`=0x3F0 and `depth`+2 total.
- **Reset during RET_WAIT**:
  - Stimulus: `ret` at `depth`=2, then `reset` on the next cycle.
  - Required: no `pc_load` after reset, `depth`=0, state IDLE, `ie`=1.
